// File: rtl/demux2_32b_buf.sv
// demux2_32b_buf: 1-to-2 demultiplexer with an independent DEPTH-entry FIFO per output.
// in_rdy depends only on in_sel and the registered occupancy of the selected FIFO,
// so a full FIFO never stalls traffic bound for the other output.
// Optional macro DEMUX2_32B_BUF_CNT_EN adds 16-bit per-output dequeue counters cnt0/cnt1.
module demux2_32b_buf #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic        in_sel,
  input  logic [31:0] in_msg,
  output logic        out0_val,
  input  logic        out0_rdy,
  output logic [31:0] out0_msg,
  output logic        out1_val,
  input  logic        out1_rdy,
  output logic [31:0] out1_msg
`ifdef DEMUX2_32B_BUF_CNT_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] rd_ptr_q [2];
  logic [PtrW-1:0] wr_ptr_q [2];
  logic [CntW-1:0] cnt_q    [2];
  logic [31:0]     mem_q    [2][DEPTH];

  logic [1:0] not_full;
  logic [1:0] val;
  logic [1:0] out_rdy;
  logic [1:0] enq;
  logic [1:0] deq;

  assign out_rdy = {out1_rdy, out0_rdy};

  // Handshake decode: ready/valid from registered counts only, one enqueue target per cycle.
  always_comb begin
    not_full = '0;
    val      = '0;
    enq      = '0;
    deq      = '0;
    for (int i = 0; i < 2; i++) begin
      not_full[i] = cnt_q[i] < CntW'(DEPTH);
      val[i]      = cnt_q[i] != '0;
      deq[i]      = val[i] & out_rdy[i];
    end
    in_rdy      = not_full[in_sel];
    enq[in_sel] = in_val & in_rdy;
  end

  // Output heads; an empty FIFO presents zero rather than stale storage.
  always_comb begin
    out0_val = val[0];
    out1_val = val[1];
    out0_msg = val[0] ? mem_q[0][rd_ptr_q[0]] : 32'h0;
    out1_msg = val[1] ? mem_q[1][rd_ptr_q[1]] : 32'h0;
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (enq[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (deq[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (enq[i] && !deq[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (deq[i] && !enq[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // Storage write; contents are don't-care after reset since pointers and counts clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (enq[i]) mem_q[i][wr_ptr_q[i]] <= in_msg;
    end
  end

`ifdef DEMUX2_32B_BUF_CNT_EN
  logic [15:0] dcnt_q [2];

  // Completed-dequeue counters, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (deq[i]) dcnt_q[i] <= dcnt_q[i] + 16'd1;
      end
    end
  end

  assign cnt0 = dcnt_q[0];
  assign cnt1 = dcnt_q[1];
`endif

endmodule

// File: tb/tb_demux2_32b_buf.sv
// Directed self-checking bench for demux2_32b_buf with DEPTH=2.
module tb_demux2_32b_buf;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic        in_sel;
  logic [31:0] in_msg;
  logic        out0_val;
  logic        out0_rdy;
  logic [31:0] out0_msg;
  logic        out1_val;
  logic        out1_rdy;
  logic [31:0] out1_msg;
`ifdef DEMUX2_32B_BUF_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  demux2_32b_buf #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_sel   (in_sel),
    .in_msg   (in_msg),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg)
`ifdef DEMUX2_32B_BUF_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] m);
    in_val = v;
    in_sel = s;
    in_msg = m;
  endtask

  int q[$];
  int rx;
  int sent;
  int cyc;
  bit enq_m;
  bit deq_m;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    step();
    step();
    check("rst_out0_val", {31'b0, out0_val}, 32'd0);
    check("rst_out1_val", {31'b0, out1_val}, 32'd0);
    check("rst_out0_msg", out0_msg, 32'h0);
    check("rst_out1_msg", out1_msg, 32'h0);
    check("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
    rst = 1'b0;
    step();

    // Route to out0
    drive(1'b1, 1'b0, 32'hDEADBEEF);
    out0_rdy = 1'b1;
    check("route_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("route_no_comb_path", {31'b0, out0_val}, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("route_out0_val", {31'b0, out0_val}, 32'd1);
    check("route_out0_msg", out0_msg, 32'hDEADBEEF);
    check("route_out1_val", {31'b0, out1_val}, 32'd0);
    step();
    check("route_drained_val", {31'b0, out0_val}, 32'd0);
    check("route_drained_msg", out0_msg, 32'h0);

    // Fill out1, no head-of-line blocking toward out0
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    drive(1'b1, 1'b1, 32'd1);
    check("fill_rdy1", {31'b0, in_rdy}, 32'd1);
    step();
    drive(1'b1, 1'b1, 32'd2);
    check("fill_rdy2", {31'b0, in_rdy}, 32'd1);
    step();
    drive(1'b1, 1'b1, 32'd3);
    check("fill_rdy3_full", {31'b0, in_rdy}, 32'd0);
    check("fill_head", out1_msg, 32'd1);
    in_sel = 1'b0;
    #1;
    check("fill_other_rdy", {31'b0, in_rdy}, 32'd1);
    drive(1'b0, 1'b1, 32'd3);
    step();
    check("fill_still_full", {31'b0, in_rdy}, 32'd0);
    out1_rdy = 1'b1;
    check("drain_first", out1_msg, 32'd1);
    step();
    check("drain_second", out1_msg, 32'd2);
    step();
    check("drain_empty", {31'b0, out1_val}, 32'd0);
    out1_rdy = 1'b0;

    // Simultaneous enqueue and dequeue at occupancy 1
    drive(1'b1, 1'b0, 32'h4);
    step();
    drive(1'b1, 1'b0, 32'h5);
    out0_rdy = 1'b1;
    check("sim_head_before", out0_msg, 32'h4);
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("sim_val", {31'b0, out0_val}, 32'd1);
    check("sim_msg", out0_msg, 32'h5);
    step();
    check("sim_occ_was_one", {31'b0, out0_val}, 32'd0);

    // Full FIFO refuses enqueue even with downstream ready
    out0_rdy = 1'b0;
    drive(1'b1, 1'b0, 32'hA);
    step();
    drive(1'b1, 1'b0, 32'hB);
    step();
    drive(1'b1, 1'b0, 32'h77);
    out0_rdy = 1'b1;
    check("full_rdy_hi_no_enq", {31'b0, in_rdy}, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("full_next_head", out0_msg, 32'hB);
    step();
    check("full_no_extra", {31'b0, out0_val}, 32'd0);

    // Inputs wiggling with in_val low have no effect
    out0_rdy = 1'b0;
    drive(1'b0, 1'b1, 32'h1234);
    step();
    drive(1'b0, 1'b0, 32'h5678);
    step();
    check("idle_out0_val", {31'b0, out0_val}, 32'd0);
    check("idle_out1_val", {31'b0, out1_val}, 32'd0);

    // Wrap: 0..9 to out0 with toggling ready, checked against a queue model
    sent = 0;
    rx = 0;
    q.delete();
    for (cyc = 0; cyc < 100 && rx < 10; cyc++) begin
      drive(sent < 10, 1'b0, 32'(sent));
      out0_rdy = (cyc % 2) == 0;
      #1;
      check("wrap_in_rdy", {31'b0, in_rdy}, {31'b0, q.size() < 2});
      check("wrap_val", {31'b0, out0_val}, {31'b0, q.size() > 0});
      if (q.size() > 0) check("wrap_msg", out0_msg, 32'(q[0]));
      enq_m = in_val && (q.size() < 2);
      deq_m = out0_rdy && (q.size() > 0);
      step();
      if (deq_m) begin
        void'(q.pop_front());
        rx++;
      end
      if (enq_m) begin
        q.push_back(sent);
        sent++;
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    out0_rdy = 1'b0;
    check("wrap_all_received", 32'(rx), 32'd10);
    check("wrap_all_sent", 32'(sent), 32'd10);

    // Reset mid-operation with both FIFOs holding two entries
    drive(1'b1, 1'b0, 32'h10);
    step();
    drive(1'b1, 1'b0, 32'h11);
    step();
    drive(1'b1, 1'b1, 32'h20);
    step();
    drive(1'b1, 1'b1, 32'h21);
    step();
    drive(1'b0, 1'b1, 32'h0);
    check("pre_rst_full1", {31'b0, in_rdy}, 32'd0);
    check("pre_rst_out0", out0_msg, 32'h10);
    rst = 1'b1;
    #2;
    check("arst_out0_val", {31'b0, out0_val}, 32'd0);
    check("arst_out1_val", {31'b0, out1_val}, 32'd0);
    check("arst_out0_msg", out0_msg, 32'h0);
    check("arst_out1_msg", out1_msg, 32'h0);
    check("arst_in_rdy", {31'b0, in_rdy}, 32'd1);
`ifdef DEMUX2_32B_BUF_CNT_EN
    check("arst_cnt0", {16'b0, cnt0}, 32'd0);
    check("arst_cnt1", {16'b0, cnt1}, 32'd0);
`endif
    rst = 1'b0;
    step();
    check("post_rst_empty", {31'b0, out1_val}, 32'd0);
    drive(1'b1, 1'b1, 32'hABC);
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("post_rst_msg", out1_msg, 32'hABC);
    out1_rdy = 1'b1;
    step();
    check("post_rst_drain", {31'b0, out1_val}, 32'd0);
`ifdef DEMUX2_32B_BUF_CNT_EN
    check("post_rst_cnt1", {16'b0, cnt1}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
